// File: rtl/macro_select_ctrl.sv
// Shares one Wishbone slave port and one pad set among N_MACRO macros; control ack 1 cycle, forwarded ack 1 cycle after macro ack or TIMEOUT+1.
// One access at a time: upstream waits while a forward is in flight; owner switch is break-before-make with a tri-state guard.
module macro_select_ctrl #(
    parameter int          N_MACRO      = 4,
    parameter int          IO_W         = 38,
    parameter int          GUARD_CYCLES = 16,
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] CTRL_BASE    = 32'h3000_0000
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [N_MACRO-1:0]      m_stb_o,
    input  logic [N_MACRO-1:0]      m_ack_i,
    input  logic [32*N_MACRO-1:0]   m_dat_i,
    input  logic [IO_W*N_MACRO-1:0] m_io_out_i,
    input  logic [IO_W*N_MACRO-1:0] m_io_oeb_i,
    output logic [IO_W-1:0]         io_out_o,
    output logic [IO_W-1:0]         io_oeb_o,
    output logic [N_MACRO-1:0]      active_o,
    output logic                    err_o
);
    localparam int          IDX_W   = (N_MACRO > 1) ? $clog2(N_MACRO) : 1;
    localparam logic [7:0]  N8      = 8'(N_MACRO);
    localparam logic [7:0]  G8      = 8'(GUARD_CYCLES);
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] BAD_DAT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GUARD = 2'd1, ST_ACTIVE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   pend_q, pend_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               busy_q;
    logic [7:0]         tcnt_q;
    logic               err_q;

    logic               accept, is_ctrl, sel_wr, sts_wr, is_active;
    logic               done_ack, done_to, err_set, err_clr;
    logic [N_MACRO-1:0] onehot;
    logic [7:0]         pend8, owner8;
    logic [31:0]        ctrl_rd;
    logic               unused_in;

    assign unused_in = ^{wbs_sel_i, wbs_dat_i[31:8]};

    // A new access is taken only when idle and not in the ack cycle of the previous one.
    assign accept    = wbs_stb_i && wbs_cyc_i && !wbs_ack_o && !busy_q;
    assign is_ctrl   = (wbs_adr_i[31:8] == CTRL_BASE[31:8]);
    assign sel_wr    = accept && is_ctrl && wbs_we_i && (wbs_adr_i[7:0] == 8'h00);
    assign sts_wr    = accept && is_ctrl && wbs_we_i && (wbs_adr_i[7:0] == 8'h04);
    assign is_active = (state_q == ST_ACTIVE);
    assign pend8     = 8'(pend_q);
    assign owner8    = 8'(owner_q);
    assign onehot    = {{(N_MACRO-1){1'b0}}, 1'b1} << owner_q;

    assign active_o  = is_active ? onehot : '0;
    assign m_stb_o   = busy_q ? onehot : '0;
    assign err_o     = err_q;

    // Macro ack beats a timeout expiring on the same cycle.
    assign done_ack  = busy_q && m_ack_i[owner_q];
    assign done_to   = busy_q && !m_ack_i[owner_q] && (tcnt_q == TO_LAST);
    assign err_set   = done_to || (accept && !is_ctrl && !is_active);
    assign err_clr   = sts_wr && wbs_dat_i[2];

    always_comb begin
        ctrl_rd = 32'h0;
        case (wbs_adr_i[7:0])
            8'h00:   ctrl_rd = is_active ? {24'h0, owner8} : 32'h0000_00FF;
            8'h04:   ctrl_rd = {16'h0, pend8, 5'h0, err_q, state_q};
            default: ctrl_rd = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        owner_d = owner_q;
        if (state_q == ST_GUARD) begin
            if (cnt_q == 8'd0) begin
                state_d = ST_ACTIVE;
                owner_d = pend_q;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
        if (sel_wr) begin
            if (wbs_dat_i[7:0] >= N8) begin
                state_d = ST_IDLE;
            end else if (!(is_active && (wbs_dat_i[7:0] == owner8))) begin
                state_d = ST_GUARD;
                cnt_d   = G8;
                pend_d  = wbs_dat_i[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            pend_q  <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            owner_q <= owner_d;
        end
    end

    // Pads drive only while ownership is stable across this edge, so they follow active_o in and leave with it.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            io_out_o <= '0;
            io_oeb_o <= '1;
        end else if (is_active && (state_d == ST_ACTIVE)) begin
            io_out_o <= m_io_out_i[IO_W*owner_q +: IO_W];
            io_oeb_o <= m_io_oeb_i[IO_W*owner_q +: IO_W];
        end else begin
            io_out_o <= '0;
            io_oeb_o <= '1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            busy_q    <= 1'b0;
            tcnt_q    <= 8'd0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            if (done_ack) begin
                busy_q    <= 1'b0;
                wbs_ack_o <= 1'b1;
                wbs_dat_o <= m_dat_i[32*owner_q +: 32];
            end else if (done_to) begin
                busy_q    <= 1'b0;
                wbs_ack_o <= 1'b1;
                wbs_dat_o <= BAD_DAT;
            end else if (busy_q) begin
                tcnt_q <= tcnt_q + 8'd1;
            end else if (accept) begin
                if (is_ctrl) begin
                    wbs_ack_o <= 1'b1;
                    wbs_dat_o <= ctrl_rd;
                end else if (is_active) begin
                    busy_q <= 1'b1;
                    tcnt_q <= 8'd0;
                end else begin
                    wbs_ack_o <= 1'b1;
                    wbs_dat_o <= BAD_DAT;
                end
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_macro_select_ctrl.sv
// Directed bench for macro_select_ctrl: vector table for single-ack accesses, hand sequences for guard, timeout and reset.
module tb_macro_select_ctrl;
    localparam int N   = 4;
    localparam int IOW = 38;
    localparam logic [31:0] CTRL = 32'h3000_0000;
    localparam logic [31:0] STS  = 32'h3000_0004;
    localparam logic [31:0] FWD  = 32'h3000_1000;
    localparam logic [31:0] BAD  = 32'hDEAD_BEEF;
    localparam logic [IOW-1:0] ALL1 = '1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stb, cyc, we;
    logic [3:0]        sel;
    logic [31:0]       adr, dat;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic [N-1:0]      m_stb_o, m_ack_i;
    logic [32*N-1:0]   m_dat_i;
    logic [IOW*N-1:0]  m_io_out_i, m_io_oeb_i;
    logic [IOW-1:0]    io_out_o, io_oeb_o;
    logic [N-1:0]      active_o;
    logic              err_o;

    int compares = 0;
    int fails    = 0;
    int multi_bad = 0, stray_stb = 0, pad_bad = 0, quiet_bad = 0;
    int dly [N];
    logic [31:0] mdat [N];
    int scnt [N] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    macro_select_ctrl dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .m_stb_o(m_stb_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
        .m_io_out_i(m_io_out_i), .m_io_oeb_i(m_io_oeb_i),
        .io_out_o(io_out_o), .io_oeb_o(io_oeb_o), .active_o(active_o), .err_o(err_o)
    );

    function automatic logic [IOW-1:0] opat(int k);
        return {6'(k + 9), 32'hC0DE_0000 | 32'(k)};
    endfunction
    function automatic logic [IOW-1:0] epat(int k);
        return IOW'(k + 1) << 4;
    endfunction

    // Macro model: ack in the dly-th cycle of its strobe (dly 0 = never acks).
    always @(posedge clk)
        for (int k = 0; k < N; k++) scnt[k] <= m_stb_o[k] ? scnt[k] + 1 : 0;

    always_comb begin
        m_ack_i = '0; m_dat_i = '0; m_io_out_i = '0; m_io_oeb_i = '0;
        for (int k = 0; k < N; k++) begin
            m_ack_i[k]              = m_stb_o[k] && (dly[k] != 0) && (scnt[k] == dly[k] - 1);
            m_dat_i[k*32 +: 32]     = mdat[k];
            m_io_out_i[k*IOW +: IOW] = opat(k);
            m_io_oeb_i[k*IOW +: IOW] = epat(k);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if ($countones(active_o) > 1) multi_bad++;
            if ((m_stb_o & ~active_o) != 0) stray_stb++;
            if (active_o == 0 && io_oeb_o != ALL1) pad_bad++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compares++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = 4'hF;
        lat = 0; rd = 32'h0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin lat = i; rd = wbs_dat_o; break; end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (lat == 0) begin
            compares++; fails++;
            $display("FAIL wb_no_ack: adr 0x%0h got no ack in 400 cycles, expected an ack", a);
        end
        @(negedge clk);
    endtask

    task automatic guard_watch(output int k);
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (active_o != 0) begin k = i; break; end
            if (io_oeb_o != ALL1 || io_out_o != 0 || m_stb_o != 0) quiet_bad++;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ack"},    wbs_ack_o, 0);
        chk({tag, "_dat"},    wbs_dat_o, 0);
        chk({tag, "_mstb"},   m_stb_o, 0);
        chk({tag, "_active"}, active_o, 0);
        chk({tag, "_oeb"},    io_oeb_o, ALL1);
        chk({tag, "_out"},    io_out_o, 0);
        chk({tag, "_err"},    err_o, 0);
    endtask

    typedef struct {
        string       name;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        chk_dat;
        logic [31:0] rdat;
        int          lat;
        logic        err;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat, k, acks;

        vecs[0]  = '{"rd_sel_idle",     1'b0, CTRL,          32'h0,         1'b1, 32'h0000_00FF, 1, 1'b0};
        vecs[1]  = '{"rd_status_rst",   1'b0, STS,           32'h0,         1'b1, 32'h0,         1, 1'b0};
        vecs[2]  = '{"rd_other_off",    1'b0, 32'h3000_0010, 32'h0,         1'b1, 32'h0,         1, 1'b0};
        vecs[3]  = '{"wr_other_off",    1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 1'b1, 32'h0,         1, 1'b0};
        vecs[4]  = '{"rd_sel_after",    1'b0, CTRL,          32'h0,         1'b1, 32'h0000_00FF, 1, 1'b0};
        vecs[5]  = '{"fwd_rd_idle",     1'b0, FWD,           32'h0,         1'b1, BAD,           1, 1'b1};
        vecs[6]  = '{"rd_status_err",   1'b0, STS,           32'h0,         1'b1, 32'h4,         1, 1'b1};
        vecs[7]  = '{"wr_status_clr",   1'b1, STS,           32'h4,         1'b0, 32'h0,         1, 1'b0};
        vecs[8]  = '{"rd_status_clr",   1'b0, STS,           32'h0,         1'b1, 32'h0,         1, 1'b0};
        vecs[9]  = '{"wr_sel_oob",      1'b1, CTRL,          32'h10,        1'b0, 32'h0,         1, 1'b0};
        vecs[10] = '{"rd_sel_oob",      1'b0, CTRL,          32'h0,         1'b1, 32'h0000_00FF, 1, 1'b0};
        vecs[11] = '{"fwd_wr_idle",     1'b1, 32'h3000_2000, 32'h55,        1'b1, BAD,           1, 1'b1};
        vecs[12] = '{"wr_status_noclr", 1'b1, STS,           32'h0,         1'b0, 32'h0,         1, 1'b1};
        vecs[13] = '{"wr_status_clr2",  1'b1, STS,           32'h4,         1'b0, 32'h0,         1, 1'b0};
        vecs[14] = '{"fwd_page_edge",   1'b0, 32'h3000_0100, 32'h0,         1'b1, BAD,           1, 1'b1};
        vecs[15] = '{"wr_status_clr3",  1'b1, STS,           32'h4,         1'b0, 32'h0,         1, 1'b0};

        for (int i = 0; i < N; i++) begin dly[i] = 0; mdat[i] = 32'hA000_0000 | 32'(i); end
        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat = 32'h0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outs("rst");
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            wb_xfer(vecs[i].w, vecs[i].a, vecs[i].d, rd, lat);
            if (vecs[i].chk_dat) chk({vecs[i].name, "_dat"}, rd, vecs[i].rdat);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            chk({vecs[i].name, "_err"}, err_o, vecs[i].err);
        end

        // First owner: guard, status during guard, restart, then grant
        wb_xfer(1'b1, CTRL, 32'h2, rd, lat);
        wb_xfer(1'b0, STS, 32'h0, rd, lat);
        chk("guard_status", rd, 32'h0000_0201);
        wb_xfer(1'b1, CTRL, 32'h2, rd, lat);
        guard_watch(k);
        chk("guard_len_first", k, 17);
        chk("active_first", active_o, 4'b0100);
        chk("pad_lag_oeb", io_oeb_o, ALL1);
        @(posedge clk); #1;
        chk("pad2_out", io_out_o, opat(2));
        chk("pad2_oeb", io_oeb_o, epat(2));
        wb_xfer(1'b0, CTRL, 32'h0, rd, lat);
        chk("rd_sel_owner2", rd, 32'h2);

        // Switch 2 -> 1: break immediately, make after the guard
        wb_xfer(1'b1, CTRL, 32'h1, rd, lat);
        chk("switch_active_drop", active_o, 0);
        chk("switch_pad_tri", io_oeb_o, ALL1);
        wb_xfer(1'b0, STS, 32'h0, rd, lat);
        chk("switch_status", rd, 32'h0000_0101);
        guard_watch(k);
        chk("guard_len_switch", k, 15);
        chk("active_second", active_o, 4'b0010);
        chk("guard_quiet", quiet_bad, 0);
        wb_xfer(1'b1, CTRL, 32'h1, rd, lat);
        chk("same_owner_active", active_o, 4'b0010);
        wb_xfer(1'b0, STS, 32'h0, rd, lat);
        chk("same_owner_status", rd, 32'h0000_0102);
        chk("pad1_out", io_out_o, opat(1));

        // Forwarding through owner 1
        dly[1] = 3; mdat[1] = 32'h1234_5678;
        wb_xfer(1'b0, FWD, 32'h0, rd, lat);
        chk("fwd_dat", rd, 32'h1234_5678);
        chk("fwd_lat", lat, 4);
        chk("fwd_err", err_o, 0);
        chk("fwd_stb_drop", m_stb_o, 0);
        dly[1] = 0;
        wb_xfer(1'b0, FWD, 32'h0, rd, lat);
        chk("to_dat", rd, BAD);
        chk("to_lat", lat, 256);
        chk("to_err", err_o, 1);
        chk("to_stb_drop", m_stb_o, 0);
        wb_xfer(1'b1, STS, 32'h4, rd, lat);
        chk("to_err_clr", err_o, 0);
        dly[1] = 255; mdat[1] = 32'hCAFE_F00D;
        wb_xfer(1'b0, FWD, 32'h0, rd, lat);
        chk("race_dat", rd, 32'hCAFE_F00D);
        chk("race_lat", lat, 256);
        chk("race_err", err_o, 0);

        // Forward during guard, then reset mid-guard
        wb_xfer(1'b1, CTRL, 32'h3, rd, lat);
        wb_xfer(1'b0, FWD, 32'h0, rd, lat);
        chk("guard_fwd_dat", rd, BAD);
        chk("guard_fwd_lat", lat, 1);
        chk("guard_fwd_err", err_o, 1);
        chk("guard_fwd_stb", m_stb_o, 0);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1 chk_reset_outs("rst_guard");
        @(negedge clk) rst_n = 1'b1;
        wb_xfer(1'b0, STS, 32'h0, rd, lat);
        chk("rst_guard_status", rd, 32'h0);
        k = 0;
        repeat (20) begin @(posedge clk); #1; if (active_o != 0) k++; end
        chk("rst_guard_no_grant", k, 0);

        // Reset in the middle of a forwarded access
        wb_xfer(1'b1, CTRL, 32'h0, rd, lat);
        guard_watch(k);
        chk("guard_len_m0", k, 17);
        dly[0] = 0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = FWD;
        repeat (5) @(posedge clk);
        #1 chk("midfwd_stb", m_stb_o, 4'b0001);
        @(negedge clk);
        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1 chk_reset_outs("rst_fwd");
        @(negedge clk) rst_n = 1'b1;
        acks = 0;
        repeat (10) begin @(posedge clk); #1; if (wbs_ack_o) acks++; end
        chk("rst_fwd_no_ack", acks, 0);

        chk("never_two_active", multi_bad, 0);
        chk("never_stray_stb", stray_stb, 0);
        chk("never_pad_unowned", pad_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
